// File: rtl/multi_head_vlink_ring.sv
// Registered vlink crossbar between NUM_HEADS head instances arranged as a ring,
// plus an IDLE/RUN tracker that collects per-head finish pulses into all_finish.
module multi_head_vlink_ring #(
   parameter int NUM_HEADS        = 4,
   parameter int VLINK_DATA_WIDTH = 128,
   parameter int NUM_LANES        = 16
) (
   input  logic                                            clk,
   input  logic                                            rst_n,
   input  logic                                            ring_cfg_vld,
   input  logic [1:0]                                      ring_cfg_mode,
   input  logic [NUM_HEADS-1:0]                            ring_cfg_head_en,
   input  logic [NUM_HEADS*NUM_LANES*VLINK_DATA_WIDTH-1:0] vlink_data_out_array,
   input  logic [NUM_HEADS*NUM_LANES-1:0]                  vlink_data_out_vld_array,
   output logic [NUM_HEADS*NUM_LANES*VLINK_DATA_WIDTH-1:0] vlink_data_in_array,
   output logic [NUM_HEADS*NUM_LANES-1:0]                  vlink_data_in_vld_array,
   input  logic                                            start,
   input  logic [NUM_HEADS-1:0]                            finish_in,
   output logic [NUM_HEADS-1:0]                            finish_status,
   output logic                                            all_finish,
   output logic                                            busy,
   output logic                                            cfg_err,
   output logic [31:0]                                     run_cycles
);

   localparam int NL_TOT = NUM_HEADS * NUM_LANES;
   localparam int W      = VLINK_DATA_WIDTH;

   typedef enum logic {IDLE, RUN} state_t;

   state_t                   state_q, state_d;
   logic [1:0]               mode_q, mode_d;
   logic [NUM_HEADS-1:0]     head_en_q, head_en_d;
   logic                     cfg_err_q, cfg_err_d;
   logic [NUM_HEADS-1:0]     finish_status_q, finish_status_d;
   logic                     all_finish_q, all_finish_d;
   logic [31:0]              run_cycles_q, run_cycles_d;
   logic [NL_TOT-1:0]        vld_q, vld_d;
   logic [NL_TOT*W-1:0]      data_q, data_d;
   logic [NUM_HEADS-1:0]     fin_hit;

   genvar gi, li;
   generate
      for (gi = 0; gi < NUM_HEADS; gi++) begin : g_head
         // Source head indices are elaboration-time constants; the mux only picks among three.
         localparam int FWD = (gi + NUM_HEADS - 1) % NUM_HEADS;
         localparam int BWD = (gi + 1) % NUM_HEADS;
         localparam int SWP = ((gi ^ 1) < NUM_HEADS) ? (gi ^ 1) : gi;

         logic [NUM_LANES-1:0]   src_vld;
         logic [NUM_LANES*W-1:0] src_data;
         logic                   src_en;

         always_comb begin
            src_vld  = vlink_data_out_vld_array[FWD*NUM_LANES +: NUM_LANES];
            src_data = vlink_data_out_array[FWD*NUM_LANES*W +: NUM_LANES*W];
            src_en   = head_en_q[FWD];
            if (mode_q == 2'd1) begin
               src_vld  = vlink_data_out_vld_array[BWD*NUM_LANES +: NUM_LANES];
               src_data = vlink_data_out_array[BWD*NUM_LANES*W +: NUM_LANES*W];
               src_en   = head_en_q[BWD];
            end else if (mode_q == 2'd2) begin
               src_vld  = vlink_data_out_vld_array[SWP*NUM_LANES +: NUM_LANES];
               src_data = vlink_data_out_array[SWP*NUM_LANES*W +: NUM_LANES*W];
               src_en   = head_en_q[SWP];
            end
         end

         assign vld_d[gi*NUM_LANES +: NUM_LANES] = (head_en_q[gi] && src_en) ? src_vld : '0;

         for (li = 0; li < NUM_LANES; li++) begin : g_lane
            assign data_d[(gi*NUM_LANES+li)*W +: W] = vld_d[gi*NUM_LANES+li] ?
                   src_data[li*W +: W] : data_q[(gi*NUM_LANES+li)*W +: W];
         end
      end
   endgenerate

   assign fin_hit = finish_in & head_en_q;

   always_comb begin
      state_d         = state_q;
      mode_d          = mode_q;
      head_en_d       = head_en_q;
      cfg_err_d       = cfg_err_q;
      finish_status_d = finish_status_q;
      run_cycles_d    = run_cycles_q;
      all_finish_d    = 1'b0;

      if (ring_cfg_vld) begin
         if (state_q == RUN) begin
            cfg_err_d = 1'b1;
         end else begin
            head_en_d = ring_cfg_head_en;
            if (ring_cfg_mode == 2'd3 || (ring_cfg_mode == 2'd2 && (NUM_HEADS % 2) != 0)) begin
               mode_d    = 2'd0;
               cfg_err_d = 1'b1;
            end else begin
               mode_d = ring_cfg_mode;
            end
         end
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d         = RUN;
               finish_status_d = '0;
               run_cycles_d    = '0;
            end
         end
         RUN: begin
            if (run_cycles_q != 32'hFFFF_FFFF) run_cycles_d = run_cycles_q + 32'd1;
            finish_status_d = finish_status_q | fin_hit;
            // Disabled heads count as finished, so an all-zero mask completes immediately.
            if (&(finish_status_q | fin_hit | ~head_en_q)) begin
               all_finish_d = 1'b1;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= IDLE;
         mode_q          <= 2'd0;
         head_en_q       <= '1;
         cfg_err_q       <= 1'b0;
         finish_status_q <= '0;
         all_finish_q    <= 1'b0;
         run_cycles_q    <= '0;
         vld_q           <= '0;
         data_q          <= '0;
      end else begin
         state_q         <= state_d;
         mode_q          <= mode_d;
         head_en_q       <= head_en_d;
         cfg_err_q       <= cfg_err_d;
         finish_status_q <= finish_status_d;
         all_finish_q    <= all_finish_d;
         run_cycles_q    <= run_cycles_d;
         vld_q           <= vld_d;
         data_q          <= data_d;
      end
   end

   assign vlink_data_in_array     = data_q;
   assign vlink_data_in_vld_array = vld_q;
   assign finish_status           = finish_status_q;
   assign all_finish              = all_finish_q;
   assign busy                    = (state_q == RUN);
   assign cfg_err                 = cfg_err_q;
   assign run_cycles              = run_cycles_q;

endmodule

// File: doc/multi_head_vlink_ring.md
MULTI_HEAD_VLINK_RING -- requirements
Module: multi_head_vlink_ring

Interface
REQ-001 SHALL have parameter NUM_HEADS, default 4, number of attached head_top instances (legal: even, >=2).
REQ-002 SHALL have parameter VLINK_DATA_WIDTH, default 128, bits per vlink lane.
REQ-003 SHALL have parameter NUM_LANES, default 16, vlink lanes per head.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port ring_cfg_vld  input  1  one-cycle strobe qualifying ring_cfg_mode and ring_cfg_head_en.
REQ-007 SHALL have port ring_cfg_mode  input  2  0=forward (h receives from h-1 mod N), 1=backward (from h+1 mod N), 2=pair swap (from h^1), 3=reserved.
REQ-008 SHALL have port ring_cfg_head_en  input  NUM_HEADS  per-head enable mask.
REQ-009 SHALL have port vlink_data_out_array  input  NUM_HEADS*NUM_LANES*VLINK_DATA_WIDTH  head outputs, head h at slice h.
REQ-010 SHALL have port vlink_data_out_vld_array  input  NUM_HEADS*NUM_LANES  per-lane valid from heads.
REQ-011 SHALL have port vlink_data_in_array  output  NUM_HEADS*NUM_LANES*VLINK_DATA_WIDTH  registered data to heads.
REQ-012 SHALL have port vlink_data_in_vld_array  output  NUM_HEADS*NUM_LANES  registered per-lane valid to heads.
REQ-013 SHALL have port start  input  1  layer start pulse (same strobe fed to heads).
REQ-014 SHALL have port finish_in  input  NUM_HEADS  per-head finish pulses.
REQ-015 SHALL have port finish_status  output  NUM_HEADS  heads finished in current run.
REQ-016 SHALL have port all_finish  output  1  one-cycle pulse, all enabled heads finished.
REQ-017 SHALL have port busy  output  1  run in progress.
REQ-018 SHALL have port cfg_err  output  1  sticky, config rejected.
REQ-019 SHALL have port run_cycles  output  32  cycles spent in current/last run.

Function
REQ-020 SHALL hold config registers mode and head_en; ring_cfg_vld loads both next cycle only when busy=0.
REQ-021 SHALL ignore ring_cfg_vld while busy=1 and set cfg_err; mode 3, or mode 2 with odd NUM_HEADS, SHALL be stored as mode 0 and set cfg_err.
REQ-022 SHALL route source lane l of head src(h) to lane l of head h per mode; lane index never changes.
REQ-023 SHALL register routed valid every cycle: exactly 1-cycle latency from vlink_data_out_vld_array to vlink_data_in_vld_array.
REQ-024 SHALL update a destination lane data register only when its routed valid is 1; otherwise data holds previous value.
REQ-025 SHALL force destination valid to 0 when destination head or source head is disabled in head_en.
REQ-026 SHALL implement FSM IDLE/RUN: IDLE->RUN on start; RUN->IDLE on cycle all_finish asserts.
REQ-027 On start in IDLE SHALL clear finish_status and run_cycles; start in RUN SHALL be ignored.
REQ-028 In RUN, finish_in[h] with head_en[h]=1 SHALL set finish_status[h]; finish_in of disabled heads and any finish_in in IDLE SHALL be ignored.
REQ-029 all_finish SHALL pulse the cycle after (finish_status | finish_in-this-cycle | ~head_en) becomes all ones in RUN, including same-cycle completion of several heads.
REQ-030 With head_en all zero, all_finish SHALL pulse the cycle after RUN is entered.
REQ-031 busy SHALL equal state==RUN; run_cycles SHALL increment each RUN cycle, saturating at 0xFFFFFFFF, holding in IDLE.
REQ-032 Routing SHALL be active in both states; only the finish tracker depends on FSM state.

Reset
REQ-033 On rst_n=0 all outputs SHALL be 0 asynchronously: data/valid registers, finish_status, all_finish, busy, cfg_err, run_cycles; state=IDLE.
REQ-034 Reset values SHALL be mode=0 and head_en all ones; reset mid-run SHALL abort the run with no all_finish pulse.

Verification
REQ-035 NUM_HEADS=4, cfg mode 0, head 0 lane 3 vld=1 data=0xA5 -> head 1 lane 3 vld=1 data=0xA5 one cycle later, other heads vld=0.
REQ-036 Mode 2, NUM_HEADS=2, both heads drive all lanes -> head 0 sees head 1 data, head 1 sees head 0 data, 1-cycle latency.
REQ-037 head_en=4'b1011, start, finish_in pulses 0,1,3 in separate cycles, plus finish_in[2] -> finish_status=4'b1011, all_finish one cycle after last enabled finish, busy falls same cycle.
REQ-038 ring_cfg_vld during RUN with mode 1 -> mode unchanged, cfg_err=1 stays set; cfg mode 3 in IDLE -> mode 0, cfg_err=1.
REQ-039 Start, 10 RUN cycles, finish all -> run_cycles=11 held in IDLE; rst_n low mid-run -> all outputs 0, no all_finish.
